// File: rtl/pacman_collision.sv
// pacman_collision
//   Detects Pac-Man/ghost contact and sequences the life-loss flow:
//   death freeze, respawn, optional post-respawn grace and game over.
//   Every decision is taken on a frame_stb tick so that it lines up with
//   sprite motion. All outputs come from registers or from the registered
//   state, so no input reaches an output combinationally.
//
//   Optional feature: define PACMAN_COLLISION_GRACE_EN to add the GRACE
//   state. In GRACE, contact is ignored for GRACE_FRAMES ticks after each
//   respawn. Without the macro, RESPAWN returns straight to PLAYING and
//   GRACE_FRAMES has no effect.
//
// Ports
//   vga_pix_clk   : sole clock
//   rst_n         : asynchronous, active-low reset
//   frame_stb     : one-cycle pulse per video frame
//   game_start    : one-cycle start request (honoured in IDLE and GAME_OVER)
//   x_pac, y_pac  : Pac-Man top-left position
//   x_blue,y_blue : ghost top-left position
//   lives         : remaining lives
//   freeze        : movers hold position while high
//   respawn       : one-cycle pulse, movers reload their start positions
//   game_over     : high in GAME_OVER
//   hit           : one-cycle pulse on a counted collision
module pacman_collision #(
  parameter int LIVES        = 3,
  parameter int HIT_RADIUS   = 4,
  parameter int DEATH_FRAMES = 90,
  parameter int GRACE_FRAMES = 120
) (
  input  logic       vga_pix_clk,
  input  logic       rst_n,
  input  logic       frame_stb,
  input  logic       game_start,
  input  logic [8:0] x_pac,
  input  logic [8:0] y_pac,
  input  logic [8:0] x_blue,
  input  logic [8:0] y_blue,
  output logic [2:0] lives,
  output logic       freeze,
  output logic       respawn,
  output logic       game_over,
  output logic       hit
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAYING   = 3'd1,
    DYING     = 3'd2,
    RESPAWN   = 3'd3,
`ifdef PACMAN_COLLISION_GRACE_EN
    GRACE     = 3'd4,
`endif
    GAME_OVER = 3'd5
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
`ifdef PACMAN_COLLISION_GRACE_EN
  localparam logic [7:0] GRACE_LAST = 8'(GRACE_FRAMES - 1);
`endif

  state_t     state, state_next;
  logic [2:0] lives_next;
  logic [7:0] cnt, cnt_next, cnt_inc;
  logic       hit_next, respawn_next;

  // Signed 10-bit differences of zero-extended 9-bit positions cover the
  // full -511..511 range, so the absolute value never overflows.
  logic signed [9:0] dx, dy;
  logic        [9:0] adx, ady;
  logic              contact;

  always_comb begin
    dx      = $signed({1'b0, x_pac}) - $signed({1'b0, x_blue});
    dy      = $signed({1'b0, y_pac}) - $signed({1'b0, y_blue});
    adx     = dx[9] ? $unsigned(-dx) : $unsigned(dx);
    ady     = dy[9] ? $unsigned(-dy) : $unsigned(dy);
    contact = (adx < 10'(HIT_RADIUS)) && (ady < 10'(HIT_RADIUS));
  end

  // The frame counter saturates so a long stall can never wrap it back
  // onto a terminal count.
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    state_next   = state;
    lives_next   = lives;
    cnt_next     = cnt;
    hit_next     = 1'b0;
    respawn_next = 1'b0;

    case (state)
      IDLE, GAME_OVER: begin
        if (game_start) begin
          lives_next   = LIVES_INIT;
          respawn_next = 1'b1;
          state_next   = PLAYING;
        end
      end
      // game_start has no branch here, so contact always wins over a
      // simultaneous start request.
      PLAYING: begin
        if (frame_stb && contact) begin
          lives_next = (lives != 3'd0) ? lives - 3'd1 : lives;
          hit_next   = 1'b1;
          state_next = DYING;
        end
      end
      DYING: begin
        if (frame_stb) begin
          if (cnt == DEATH_LAST) begin
            state_next = (lives == 3'd0) ? GAME_OVER : RESPAWN;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      RESPAWN: begin
`ifdef PACMAN_COLLISION_GRACE_EN
        state_next = GRACE;
`else
        state_next = PLAYING;
`endif
      end
`ifdef PACMAN_COLLISION_GRACE_EN
      GRACE: begin
        if (frame_stb) begin
          if (cnt == GRACE_LAST) begin
            state_next = PLAYING;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase

    // Every state starts counting from zero.
    if (state_next != state) begin
      cnt_next = 8'd0;
    end

    // Registering the pulse on entry keeps respawn high for exactly the
    // single RESPAWN cycle without decoding it from an input.
    if (state_next == RESPAWN) begin
      respawn_next = 1'b1;
    end
  end

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lives   <= 3'd0;
      cnt     <= 8'd0;
      hit     <= 1'b0;
      respawn <= 1'b0;
    end else begin
      state   <= state_next;
      lives   <= lives_next;
      cnt     <= cnt_next;
      hit     <= hit_next;
      respawn <= respawn_next;
    end
  end

  always_comb begin
    freeze    = 1'b1;
    game_over = (state == GAME_OVER);
    if (state == PLAYING) begin
      freeze = 1'b0;
    end
`ifdef PACMAN_COLLISION_GRACE_EN
    if (state == GRACE) begin
      freeze = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_pacman_collision.sv
// tb_pacman_collision
//   Directed, table-driven bench for pacman_collision with default
//   parameters (LIVES=3, HIT_RADIUS=4, DEATH_FRAMES=90, GRACE_FRAMES=120).
//   Pac-Man sits at (100,100); only the ghost position is varied.
module tb_pacman_collision;

  localparam int DEATH_FRAMES = 90;
  localparam int GRACE_FRAMES = 120;

  logic       vga_pix_clk = 1'b0;
  logic       rst_n;
  logic       frame_stb;
  logic       game_start;
  logic [8:0] x_pac, y_pac, x_blue, y_blue;
  logic [2:0] lives;
  logic       freeze, respawn, game_over, hit;

  int errors = 0;
  int checks = 0;

  always #5 vga_pix_clk = ~vga_pix_clk;

  pacman_collision dut (
    .vga_pix_clk(vga_pix_clk),
    .rst_n      (rst_n),
    .frame_stb  (frame_stb),
    .game_start (game_start),
    .x_pac      (x_pac),
    .y_pac      (y_pac),
    .x_blue     (x_blue),
    .y_blue     (y_blue),
    .lives      (lives),
    .freeze     (freeze),
    .respawn    (respawn),
    .game_over  (game_over),
    .hit        (hit)
  );

  typedef struct {
    string      name;
    logic       gs;
    logic       fs;
    logic [8:0] xb;
    logic [8:0] yb;
    logic [2:0] e_lives;
    logic       e_freeze;
    logic       e_respawn;
    logic       e_game_over;
    logic       e_hit;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] l, input logic f,
                           input logic r, input logic g, input logic h);
    check_output({tag, " lives"},     32'(lives),     32'(l));
    check_output({tag, " freeze"},    32'(freeze),    32'(f));
    check_output({tag, " respawn"},   32'(respawn),   32'(r));
    check_output({tag, " game_over"}, 32'(game_over), 32'(g));
    check_output({tag, " hit"},       32'(hit),       32'(h));
  endtask

  // Drive inputs for one cycle, cross the sampling edge, and leave the
  // bench 1 ns after it so outputs are stable when checked.
  task automatic apply_stimulus(input logic gs, input logic fs,
                                input logic [8:0] xb, input logic [8:0] yb);
    game_start = gs;
    frame_stb  = fs;
    x_blue     = xb;
    y_blue     = yb;
    @(posedge vga_pix_clk);
    #1;
    game_start = 1'b0;
    frame_stb  = 1'b0;
  endtask

  // One frame tick in contact followed by an idle cycle.
  task automatic contact_frame();
    apply_stimulus(1'b0, 1'b1, 9'd103, 9'd97);
    apply_stimulus(1'b0, 1'b0, 9'd103, 9'd97);
  endtask

  // Called just after a counted hit. Holds contact through DYING and checks
  // the exit: a one-cycle respawn pulse, or GAME_OVER when no lives remain.
  task automatic death_sequence(input logic [2:0] l, input bit expect_over);
    for (int i = 0; i < DEATH_FRAMES - 1; i++) begin
      contact_frame();
    end
    check_all("dying after 89 frames", l, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 9'd103, 9'd97);
    if (expect_over) begin
      check_all("game over entry", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 9'd103, 9'd97);
      check_all("game over hold", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      check_all("respawn pulse", l, 1'b1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 9'd103, 9'd97);
      check_all("after respawn", l, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PACMAN_COLLISION_GRACE_EN
      for (int i = 0; i < GRACE_FRAMES; i++) begin
        contact_frame();
      end
      check_all("grace ignores contact", l, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    end
  endtask

  vec_t vecs[9];

  initial begin
    // Reset vectors: Pac-Man fixed at (100,100), ghost far away.
    vecs[0] = '{"idle no start",      1'b0, 1'b0, 9'd200, 9'd200, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"start",              1'b1, 1'b0, 9'd200, 9'd200, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"playing",            1'b0, 1'b0, 9'd200, 9'd200, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"dx=-4 no hit",       1'b0, 1'b1, 9'd104, 9'd100, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"dy=-4 no hit",       1'b0, 1'b1, 9'd100, 9'd104, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"dx=+4 no hit",       1'b0, 1'b1, 9'd96,  9'd100, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"dx=-3 dy=+4 no hit", 1'b0, 1'b1, 9'd103, 9'd96,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"dx=-3 dy=+3 hit",    1'b0, 1'b1, 9'd103, 9'd97,  3'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{"hit pulse ends",     1'b0, 1'b0, 9'd103, 9'd97,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n      = 1'b0;
    frame_stb  = 1'b0;
    game_start = 1'b0;
    x_pac      = 9'd100;
    y_pac      = 9'd100;
    x_blue     = 9'd200;
    y_blue     = 9'd200;
    #12;
    check_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #5;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].gs, vecs[i].fs, vecs[i].xb, vecs[i].yb);
      check_all(vecs[i].name, vecs[i].e_lives, vecs[i].e_freeze,
                vecs[i].e_respawn, vecs[i].e_game_over, vecs[i].e_hit);
    end

    // First death, then two more hits down to game over.
    death_sequence(3'd2, 1'b0);
    apply_stimulus(1'b0, 1'b1, 9'd103, 9'd97);
    check_all("second hit", 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    death_sequence(3'd1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 9'd103, 9'd97);
    check_all("third hit", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    death_sequence(3'd0, 1'b1);

    // Restart from GAME_OVER.
    apply_stimulus(1'b1, 1'b0, 9'd200, 9'd200);
    check_all("restart", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 9'd200, 9'd200);
    check_all("restart settle", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Contact and game_start together: one decrement, start dropped.
    apply_stimulus(1'b1, 1'b1, 9'd103, 9'd97);
    check_all("hit with start", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 9'd103, 9'd97);
    check_all("start dropped", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-DYING with the counter at 40.
    for (int i = 0; i < 40; i++) begin
      contact_frame();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async reset in dying", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge vga_pix_clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 9'd103, 9'd97);
    check_all("idle after reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // A reset landing inside a respawn pulse cuts it immediately.
    apply_stimulus(1'b1, 1'b0, 9'd200, 9'd200);
    check_all("start before cut", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("respawn cut", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge vga_pix_clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 9'd200, 9'd200);
    check_all("idle after cut", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
